// File: rtl/fpu_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with round-to-nearest-even.
// Stages: unpack/swap, align, add + leading-zero count, normalise/round/pack.
module fpu_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 valid_in,
    input  logic [EXP_W+MAN_W:0] opa,
    input  logic [EXP_W+MAN_W:0] opb,
    input  logic                 sub,
    output logic                 valid_out,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid,
    output logic                 inexact
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int M   = MAN_W + 4;
    localparam int EW  = EXP_W + 2;
    localparam int RW  = MAN_W + 2;
    localparam int LZW = $clog2(M + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EXP_INF  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Stage 1: unpack, classify, swap so the "l" operand has the larger magnitude
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic sa, sb, a_nan, b_nan, a_inf, b_inf, swap, u_special, u_invalid;
    logic [W-1:0] u_sp_result;

    always_comb begin
        sa = opa[W-1];
        sb = opb[W-1] ^ sub;
        ea = opa[W-2:MAN_W];
        eb = opb[W-2:MAN_W];
        fa = (ea == '0) ? '0 : opa[MAN_W-1:0];
        fb = (eb == '0) ? '0 : opb[MAN_W-1:0];
        a_nan = (ea == EXP_ONES) && (fa != '0);
        b_nan = (eb == EXP_ONES) && (fb != '0);
        a_inf = (ea == EXP_ONES) && (fa == '0);
        b_inf = (eb == EXP_ONES) && (fb == '0);
        swap = {eb, fb} > {ea, fa};
        u_invalid = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
        u_special = a_nan | b_nan | a_inf | b_inf;
        if (u_invalid)
            u_sp_result = QNAN;
        else if (a_inf)
            u_sp_result = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else
            u_sp_result = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end

    logic             s1_valid, s1_sign_l, s1_sign_s, s1_zero_l, s1_zero_s;
    logic [EXP_W-1:0] s1_exp_l, s1_diff;
    logic [MAN_W-1:0] s1_frac_l, s1_frac_s;
    logic             s1_special, s1_invalid;
    logic [W-1:0]     s1_sp_result;

    // Stage 2: align the smaller mantissa, folding shifted-out bits into sticky
    logic [M-1:0] mant_s_full, al_mask, aligned;

    always_comb begin
        mant_s_full = {~s1_zero_s, s1_frac_s, 3'b000};
        al_mask = '0;
        aligned = '0;
        if (32'(s1_diff) >= 32'(MAN_W + 3)) begin
            aligned[0] = |mant_s_full;
        end else begin
            al_mask    = ~({M{1'b1}} << s1_diff);
            aligned    = mant_s_full >> s1_diff;
            aligned[0] = aligned[0] | (|(mant_s_full & al_mask));
        end
    end

    logic             s2_valid, s2_sign, s2_eff_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [M-1:0]     s2_mant_l, s2_mant_s;
    logic             s2_special, s2_invalid;
    logic [W-1:0]     s2_sp_result;

    // Stage 3: magnitude add/subtract and leading-zero count
    logic [M:0]     sum;
    logic [LZW-1:0] lzc;

    always_comb begin
        sum = s2_eff_sub ? ({1'b0, s2_mant_l} - {1'b0, s2_mant_s})
                         : ({1'b0, s2_mant_l} + {1'b0, s2_mant_s});
        lzc = '0;
        for (int i = 0; i < M; i++)
            if (sum[i]) lzc = LZW'(M - 1 - i);
    end

    logic             s3_valid, s3_sign, s3_eff_sub;
    logic [EXP_W-1:0] s3_exp;
    logic [M:0]       s3_sum;
    logic [LZW-1:0]   s3_lzc;
    logic             s3_special, s3_invalid;
    logic [W-1:0]     s3_sp_result;

    // Stage 4: normalise, round, detect range exceptions, pack
    logic [M-1:0]     norm;
    logic [EW-1:0]    exp_n, exp_r;
    logic [RW-1:0]    rounded;
    logic [MAN_W-1:0] frac_r;
    logic             rnd_inc, r_ovf, r_unf, r_inx, r_inv;
    logic [W-1:0]     r_result;

    always_comb begin
        if (s3_sum[M]) begin
            norm    = s3_sum[M:1];
            norm[0] = s3_sum[1] | s3_sum[0];
            exp_n   = {2'b00, s3_exp} + EW'(1);
        end else begin
            norm  = s3_sum[M-1:0] << s3_lzc;
            exp_n = {2'b00, s3_exp} - EW'(s3_lzc);
        end
        rnd_inc = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded = {1'b0, norm[M-1:3]} + RW'(rnd_inc);
        exp_r   = exp_n + EW'(rounded[MAN_W+1]);
        frac_r  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        r_ovf = 1'b0;
        r_unf = 1'b0;
        r_inv = 1'b0;
        r_inx = |norm[2:0];
        if (s3_special) begin
            r_result = s3_sp_result;
            r_inv    = s3_invalid;
            r_inx    = 1'b0;
        end else if (s3_sum == '0) begin
            // exact cancellation is +0; only (-0)+(-0) keeps the minus sign
            r_result = {~s3_eff_sub & s3_sign, {(W-1){1'b0}}};
            r_inx    = 1'b0;
        end else if (!exp_r[EW-1] && exp_r >= EXP_INF) begin
            r_result = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
            r_ovf    = 1'b1;
            r_inx    = 1'b1;
        end else if (exp_r[EW-1] || exp_r == '0) begin
            r_result = {s3_sign, {(W-1){1'b0}}};
            r_unf    = 1'b1;
            r_inx    = 1'b1;
        end else begin
            r_result = {s3_sign, exp_r[EXP_W-1:0], frac_r};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0; s1_sign_l <= 1'b0; s1_sign_s <= 1'b0;
            s1_zero_l <= 1'b0; s1_zero_s <= 1'b0; s1_exp_l <= '0; s1_diff <= '0;
            s1_frac_l <= '0; s1_frac_s <= '0;
            s1_special <= 1'b0; s1_invalid <= 1'b0; s1_sp_result <= '0;
            s2_valid <= 1'b0; s2_sign <= 1'b0; s2_eff_sub <= 1'b0; s2_exp <= '0;
            s2_mant_l <= '0; s2_mant_s <= '0;
            s2_special <= 1'b0; s2_invalid <= 1'b0; s2_sp_result <= '0;
            s3_valid <= 1'b0; s3_sign <= 1'b0; s3_eff_sub <= 1'b0; s3_exp <= '0;
            s3_sum <= '0; s3_lzc <= '0;
            s3_special <= 1'b0; s3_invalid <= 1'b0; s3_sp_result <= '0;
            valid_out <= 1'b0; result <= '0;
            overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
        end else if (enable) begin
            s1_valid     <= valid_in;
            s1_sign_l    <= swap ? sb : sa;
            s1_sign_s    <= swap ? sa : sb;
            s1_zero_l    <= swap ? (eb == '0) : (ea == '0);
            s1_zero_s    <= swap ? (ea == '0) : (eb == '0);
            s1_exp_l     <= swap ? eb : ea;
            s1_diff      <= swap ? (eb - ea) : (ea - eb);
            s1_frac_l    <= swap ? fb : fa;
            s1_frac_s    <= swap ? fa : fb;
            s1_special   <= u_special;
            s1_invalid   <= u_invalid;
            s1_sp_result <= u_sp_result;

            s2_valid     <= s1_valid;
            s2_sign      <= s1_sign_l;
            s2_eff_sub   <= s1_sign_l ^ s1_sign_s;
            s2_exp       <= s1_exp_l;
            s2_mant_l    <= {~s1_zero_l, s1_frac_l, 3'b000};
            s2_mant_s    <= aligned;
            s2_special   <= s1_special;
            s2_invalid   <= s1_invalid;
            s2_sp_result <= s1_sp_result;

            s3_valid     <= s2_valid;
            s3_sign      <= s2_sign;
            s3_eff_sub   <= s2_eff_sub;
            s3_exp       <= s2_exp;
            s3_sum       <= sum;
            s3_lzc       <= lzc;
            s3_special   <= s2_special;
            s3_invalid   <= s2_invalid;
            s3_sp_result <= s2_sp_result;

            valid_out <= s3_valid;
            result    <= r_result;
            overflow  <= r_ovf;
            underflow <= r_unf;
            invalid   <= r_inv;
            inexact   <= r_inx;
        end
    end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Bench for fpu_addsub_pipe: exact-integer reference model with a cycle-accurate
// expected-output queue, directed vectors at single and half-like precision.
module tb_fpu_addsub_pipe;
    logic clk = 1'b0;
    logic rst, enable;
    logic vin, sb;
    logic [31:0] a, b;
    logic hvin, hsb;
    logic [15:0] ha, hb;
    logic vo, ovf, unf, inv, inx;
    logic [31:0] res;
    logic hvo, hovf, hunf, hinv, hinx;
    logic [15:0] hres;

    always #5 clk = ~clk;

    fpu_addsub_pipe dut (
        .clk(clk), .rst(rst), .enable(enable), .valid_in(vin), .opa(a), .opb(b), .sub(sb),
        .valid_out(vo), .result(res), .overflow(ovf), .underflow(unf), .invalid(inv),
        .inexact(inx));

    fpu_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .enable(enable), .valid_in(hvin), .opa(ha), .opb(hb), .sub(hsb),
        .valid_out(hvo), .result(hres), .overflow(hovf), .underflow(hunf), .invalid(hinv),
        .inexact(hinx));

    typedef struct packed {
        logic [31:0] res;
        logic ovf, unf, inv, inx;
    } exp_t;
    typedef struct { exp_t e; int cnt; } ent_t;
    typedef struct packed {
        logic [31:0] a, b;
        logic s;
        logic [31:0] res;
        logic [3:0] flg;
    } vec_t;

    // flags nibble: {overflow, underflow, invalid, inexact}
    vec_t vf[18] = '{
        '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0},
        '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'h0},
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1},
        '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h2},
        '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h2},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h9},
        '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'h0},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0},
        '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'h0},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0},
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h5},
        '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0},
        '{32'h40000000, 32'h33C00000, 1'b1, 32'h3FFFFFFF, 4'h1},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h2},
        '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0}
    };
    vec_t vh[5] = '{
        '{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'h0},
        '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'h9},
        '{32'h3C00, 32'h4000, 1'b1, 32'hBC00, 4'h0},
        '{32'h7C00, 32'hFC00, 1'b0, 32'h7E00, 4'h2},
        '{32'h3C00, 32'h1000, 1'b0, 32'h3C00, 4'h1}
    };

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Exact reference: scale both operands onto a common integer grid 72 bits finer
    // than the larger operand's LSB, add exactly, then round to nearest even.
    function automatic exp_t model(input int ew, input int mw, input logic [31:0] x_in,
                                   input logic [31:0] y_in, input logic s);
        exp_t r;
        longint emax, ea, eb, fa, fb, ma, mb, el, es, ml, ms, e, fmask;
        logic sa, sbb, sl, ss;
        logic [127:0] x, y, sm, q, rem, half;
        int p, sh;
        r = '0;
        emax = (longint'(1) << ew) - 1;
        fmask = (longint'(1) << mw) - 1;
        sa = x_in[ew+mw];
        sbb = y_in[ew+mw] ^ s;
        ea = longint'(x_in >> mw) & emax;
        eb = longint'(y_in >> mw) & emax;
        fa = (ea == 0) ? 0 : (longint'(x_in) & fmask);
        fb = (eb == 0) ? 0 : (longint'(y_in) & fmask);
        if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
            (ea == emax && eb == emax && sa != sbb)) begin
            r.res = 32'((emax << mw) | (longint'(1) << (mw - 1)));
            r.inv = 1'b1;
            return r;
        end
        if (ea == emax || eb == emax) begin
            r.res = 32'(emax << mw);
            r.res[ew+mw] = (ea == emax) ? sa : sbb;
            return r;
        end
        ma = (ea == 0) ? 0 : ((longint'(1) << mw) | fa);
        mb = (eb == 0) ? 0 : ((longint'(1) << mw) | fb);
        if (((eb << mw) | fb) > ((ea << mw) | fa)) begin
            el = eb; ml = mb; sl = sbb; es = ea; ms = ma; ss = sa;
        end else begin
            el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sbb;
        end
        x = 128'(ml) << 72;
        if (ms == 0) y = '0;
        else if (el - es > 72) y = 128'(1);
        else y = 128'(ms) << (72 - (el - es));
        sm = (sl == ss) ? x + y : x - y;
        if (sm == '0) begin
            r.res[ew+mw] = (sl == ss) && sl;
            return r;
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (sm[i]) p = i;
        e = el + p - mw - 72;
        sh = p - mw;
        if (sh > 0) begin
            q = sm >> sh;
            rem = sm & ((128'(1) << sh) - 1);
            half = 128'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (128'(1) << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            r.inx = (rem != '0);
        end else begin
            q = sm << (-sh);
        end
        if (e >= emax) begin
            r.res = 32'(emax << mw);
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else if (e <= 0) begin
            r.res = '0;
            r.unf = 1'b1;
            r.inx = 1'b1;
        end else begin
            r.res = 32'(e << mw) | 32'(q & 128'(fmask));
        end
        r.res[ew+mw] = sl;
        return r;
    endfunction

    // Reference pipeline bookkeeping at the active edge
    ent_t qf[$], qh[$];
    int en_cnt = 0;
    bit adv = 0, was_rst = 0, started = 0;

    always @(posedge clk) begin
        started = 1;
        was_rst = rst;
        adv = enable && !rst;
        if (rst) begin
            qf.delete();
            qh.delete();
        end else if (enable) begin
            en_cnt++;
            if (vin) qf.push_back('{e: model(8, 23, a, b, sb), cnt: en_cnt});
            if (hvin) qh.push_back('{e: model(5, 10, {16'h0, ha}, {16'h0, hb}, hsb), cnt: en_cnt});
        end
    end

    bit last_vo = 0, last_hvo = 0;
    logic [31:0] last_res = '0, last_hres = '0;

    always @(negedge clk) begin
        exp_t e;
        bit exp_vo;
        if (started) begin
            if (was_rst) begin
                chk("rst_valid", 32'(vo), 32'h0);
                chk("rst_result", res, 32'h0);
                chk("rst_flags", 32'({ovf, unf, inv, inx}), 32'h0);
                chk("rst_hvalid", 32'(hvo), 32'h0);
                last_vo = 0;
                last_hvo = 0;
            end else if (adv) begin
                chk("no_x", 32'($isunknown({vo, res, ovf, unf, inv, inx, hvo, hres})), 32'h0);
                exp_vo = qf.size() > 0 && qf[0].cnt + 3 == en_cnt;
                chk("valid", 32'(vo), 32'(exp_vo));
                last_vo = 0;
                if (exp_vo) begin
                    e = qf.pop_front().e;
                    chk("result", res, e.res);
                    chk("flags", 32'({ovf, unf, inv, inx}), 32'({e.ovf, e.unf, e.inv, e.inx}));
                    last_vo = 1;
                    last_res = e.res;
                end
                exp_vo = qh.size() > 0 && qh[0].cnt + 3 == en_cnt;
                chk("hvalid", 32'(hvo), 32'(exp_vo));
                last_hvo = 0;
                if (exp_vo) begin
                    e = qh.pop_front().e;
                    chk("hresult", 32'(hres), e.res);
                    chk("hflags", 32'({hovf, hunf, hinv, hinx}), 32'({e.ovf, e.unf, e.inv, e.inx}));
                    last_hvo = 1;
                    last_hres = e.res;
                end
            end else begin
                chk("stall_valid", 32'(vo), 32'(last_vo));
                if (last_vo) chk("stall_result", res, last_res);
                chk("stall_hvalid", 32'(hvo), 32'(last_hvo));
                if (last_hvo) chk("stall_hresult", 32'(hres), last_hres);
            end
        end
    end

    initial begin
        exp_t m;
        rst = 1'b1; enable = 1'b1;
        vin = 1'b0; a = '0; b = '0; sb = 1'b0;
        hvin = 1'b0; ha = '0; hb = '0; hsb = 1'b0;

        foreach (vf[i]) begin
            m = model(8, 23, vf[i].a, vf[i].b, vf[i].s);
            chk("pin_res", m.res, vf[i].res);
            chk("pin_flg", 32'({m.ovf, m.unf, m.inv, m.inx}), 32'(vf[i].flg));
        end
        foreach (vh[i]) begin
            m = model(5, 10, vh[i].a, vh[i].b, vh[i].s);
            chk("pin_hres", m.res, vh[i].res);
            chk("pin_hflg", 32'({m.ovf, m.unf, m.inv, m.inx}), 32'(vh[i].flg));
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vf[i]) begin
            vin = 1'b1; a = vf[i].a; b = vf[i].b; sb = vf[i].s;
            @(negedge clk);
        end
        vin = 1'b0;
        repeat (6) @(negedge clk);

        foreach (vh[i]) begin
            hvin = 1'b1; ha = vh[i].a[15:0]; hb = vh[i].b[15:0]; hsb = vh[i].s;
            @(negedge clk);
        end
        hvin = 1'b0;
        repeat (6) @(negedge clk);

        // stall with two operations still in flight; valid_in during stall is ignored
        for (int i = 0; i < 3; i++) begin
            vin = 1'b1; a = vf[i].a; b = vf[i].b; sb = vf[i].s;
            @(negedge clk);
        end
        vin = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        vin = 1'b1; a = 32'h7FC00000; b = 32'h3F800000;
        repeat (5) @(negedge clk);
        vin = 1'b0; enable = 1'b1;
        repeat (6) @(negedge clk);

        // reset with two operations in flight, enable low to show reset wins
        for (int i = 3; i < 5; i++) begin
            vin = 1'b1; a = vf[i].a; b = vf[i].b; sb = vf[i].s;
            hvin = 1'b1; ha = vh[i].a[15:0]; hb = vh[i].b[15:0]; hsb = vh[i].s;
            @(negedge clk);
        end
        vin = 1'b0; hvin = 1'b0;
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        repeat (6) @(negedge clk);

        // one more operation after reset release
        vin = 1'b1; a = vf[8].a; b = vf[8].b; sb = vf[8].s;
        @(negedge clk);
        vin = 1'b0;
        repeat (6) @(negedge clk);

        chk("drain_full", 32'(qf.size()), 32'h0);
        chk("drain_half", 32'(qh.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_pipe.md
# fpu_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor, the next generation of the single-precision `fpu_add` datapath. It takes two operands and an add/sub select, aligns, adds, normalises and rounds (round-to-nearest-even), and delivers a packed result with exception flags after a fixed four-stage latency. One operation can be accepted per cycle, and the whole pipeline stalls under `enable`. It sits in the FPU between operand registers and the result writeback.

## Interface
- `EXP_W`, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- `MAN_W`, 23, stored fraction width (hidden bit not stored); W = 1+EXP_W+MAN_W
- `clk`  input  1  rising-edge clock; one clock for the whole block
- `rst`  input  1  synchronous, active-high reset
- `enable`  input  1  pipeline advance; 0 freezes every stage
- `valid_in`  input  1  opa/opb/sub are a new operation this cycle
- `opa`  input  W  operand A {sign, exponent, fraction}
- `opb`  input  W  operand B
- `sub`  input  1  0: opa+opb, 1: opa−opb (inverts opb sign)
- `valid_out`  output  1  result and flags valid
- `result`  output  W  packed rounded result
- `overflow`  output  1  finite result rounded beyond max finite, so result = ±inf
- `underflow`  output  1  nonzero result below min normal, flushed to ±0
- `invalid`  output  1  NaN input, or inf − inf; result = canonical qNaN
- `inexact`  output  1  guard/round/sticky nonzero, or overflow/underflow

## Operation
- S1 unpack: split fields; exp==0 operands are treated as zero (denormals flushed, sign kept). Classify zero/inf/NaN. Effective sign of B = opb.sign ^ sub. Swap so A holds the larger magnitude ({exp, frac} compare). Diff = expA − expB, EXP_W bits unsigned.
- S2 align: mantissa = {1, frac, 3'b000} (MAN_W+4 bits: guard, round, sticky). Right-shift B by diff; shifted-out bits OR into sticky. Diff ≥ MAN_W+3 gives B = sticky only (1 if B nonzero).
- S3 add: same effective signs add; otherwise A−B (never negative after swap). Sum width MAN_W+5 (carry bit). Leading-zero count computed on the sum.
- S4 normalise/round/pack: on carry, shift right 1, exp+1, old LSB ORs into sticky; else shift left by LZC, exp−LZC. RNE: increment when G && (R || S || LSB). Mantissa carry-out from rounding renormalises (exp+1). Exp ≥ 2^EXP_W−1 → ±inf + overflow. Exp ≤ 0 with nonzero sum → ±0 + underflow.
- Exact zero sum of opposite-sign operands → +0. (−0)+(−0) → −0.
- Specials override arithmetic: any NaN, or inf with opposite effective-sign inf → {0, all-ones exp, 1, zeros} (0x7FC00000 at defaults) with invalid=1. A single inf, or two same-sign infs → that inf, no flags.
- Flags are per result, not sticky, and valid only with valid_out.

## Timing
- Latency 4 enabled cycles: valid_in sampled at edge N with enable=1 → valid_out=1 after edge N+3 (visible in cycle N+4) when enable stays high. Throughput 1/cycle.
- enable=0: all stage registers, including valids and outputs, hold. Inputs are ignored that cycle, including valid_in.
- Bubbles: valid_in=0 propagates as valid_out=0. Output data under valid_out=0 is don't-care, but outputs must not be X after reset.
- Reset: all valid bits 0; result, overflow, underflow, invalid and inexact are 0 on the edge rst is sampled high. Reset overrides enable. In-flight operations are discarded, with no output for them after release.
- Back-to-back operations with differing specials must not interfere; each stage carries its own class bits.

## Test plan
- Stream 0x3F800000+0x3F800000, 0x3FC00000+0x40100000, 0x3F800000−0x3F800000 on consecutive cycles → 0x40000000, 0x40700000, 0x00000000 on consecutive valid_out, all flags 0.
- Rounding: 0x3F800000+0x33800000 → 0x3F800000 inexact=1 (tie to even); 0x3F800000+0x33C00000 → 0x3F800001 inexact=1.
- Specials: 0x7F800000+0xFF800000 → 0x7FC00000 invalid=1; 0x7F800000+0x3F800000 → 0x7F800000 no flags; 0x7FC00001+0x3F800000 → 0x7FC00000 invalid=1.
- Overflow/cancellation: 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 overflow=1 inexact=1; 0x3F800001−0x3F800000 → 0x34000000 exact.
- Stall/reset: issue 3 ops, drop enable for 5 cycles mid-flight → outputs frozen, then the 3 results appear in order. Assert rst with 2 ops in flight → valid_out=0 and result=0 next cycle, and no stale result after release.
- Parameter sweep: EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000; 0x7BFF+0x7BFF → 0x7C00 overflow=1.
